// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/control bundle between execute and the mul/div sequencer
//
// Purpose
//   Groups the execute-stage request, pipeline-control and datapath-control
//   signals of the multiply/divide sequencer into one bundle.
//
// Signals
//   valid_i     execute-stage instruction valid
//   start_i     instruction is a MUL/DIV/REM op
//   is_div_i    1 = divide/remainder, 0 = multiply
//   is_word_i   W-suffix (32-bit) op
//   div_zero_i  divisor is zero (sampled at request only)
//   flush_i     pipeline flush, aborts the op in flight
//   stall_i     memory stage stalled, hold the finished result
//   load_o      datapath latches operands at this edge
//   iter_en_o   datapath performs one iteration this cycle
//   word_o      word flag of the op in flight
//   div_o       divide flag of the op in flight
//   dz_o        divide-by-zero flag of the op in flight
//   busy_o      op accepted or in flight, result not ready
//   done_o      result valid this cycle
//   count_o     remaining iterations
//
// Modports
//   master  execute side (drives requests, observes control)
//   slave   sequencer side

interface muldiv_sequencer_if #(
  parameter int CNT_W = 7
);
  logic             valid_i;
  logic             start_i;
  logic             is_div_i;
  logic             is_word_i;
  logic             div_zero_i;
  logic             flush_i;
  logic             stall_i;
  logic             load_o;
  logic             iter_en_o;
  logic             word_o;
  logic             div_o;
  logic             dz_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output valid_i, start_i, is_div_i, is_word_i, div_zero_i, flush_i, stall_i,
    input  load_o, iter_en_o, word_o, div_o, dz_o, busy_o, done_o, count_o
  );

  modport slave (
    input  valid_i, start_i, is_div_i, is_word_i, div_zero_i, flush_i, stall_i,
    output load_o, iter_en_o, word_o, div_o, dz_o, busy_o, done_o, count_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - FSM sequencing the iterative multiply/divide datapath
//
// Purpose
//   Accepts one MUL/DIV/REM request at a time from execute, loads the
//   operands, enables one datapath iteration per cycle for the op's
//   iteration count, then presents done_o. busy_o feeds execute's stall;
//   flush_i aborts, stall_i holds the finished result.
//
// Parameters
//   MUL_CYCLES  iterations for any multiply
//   DIV_CYCLES  iterations for 64-bit divide/remainder (W forms use half)
//   CNT_W       iteration counter width
//
// Ports
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    muldiv_sequencer_if.slave (request, flush/stall, datapath control)

module muldiv_sequencer #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 64,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  muldiv_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_N  = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] DIVW_N = CNT_W'(DIV_CYCLES / 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             word_q, word_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;

  logic             req;
  logic             load;
  logic             iter_en;
  logic             busy;
  logic             done;

  // A flushed request is never a request: it is dropped, not deferred.
  assign req = bus.valid_i & bus.start_i & ~bus.flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      word_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    div_d   = div_q;
    dz_d    = dz_q;
    load    = 1'b0;
    iter_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          // busy is raised in the request cycle itself so execute stalls
          // before the next instruction can advance.
          load   = 1'b1;
          busy   = 1'b1;
          word_d = bus.is_word_i;
          div_d  = bus.is_div_i;
          dz_d   = bus.div_zero_i;
          if (bus.is_div_i && bus.div_zero_i) begin
            // The datapath substitutes the ISA result; no iterations needed.
            state_d = DONE;
            count_d = '0;
          end else begin
            state_d = RUN;
            if (!bus.is_div_i) begin
              count_d = MUL_N;
            end else if (bus.is_word_i) begin
              count_d = DIVW_N;
            end else begin
              count_d = DIV_N;
            end
          end
        end
      end

      RUN: begin
        iter_en = 1'b1;
        busy    = 1'b1;
        // <=1 rather than ==1 so a zero count can never wrap and spin.
        if (count_q <= CNT_W'(1)) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end

      DONE: begin
        done = 1'b1;
        if (!bus.stall_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Flush wins over everything but reset. Current-cycle outputs still
    // reflect the current state, except operand load which must not fire.
    if (bus.flush_i) begin
      state_d = IDLE;
      count_d = '0;
      load    = 1'b0;
    end
  end

  // Op flags are only meaningful while an op is in flight; in IDLE they
  // read as zero so the datapath never sees stale flags.
  logic active;
  assign active = (state_q != IDLE);

  assign bus.load_o    = load;
  assign bus.iter_en_o = iter_en;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.word_o    = word_q & active;
  assign bus.div_o     = div_q & active;
  assign bus.dz_o      = dz_q & active;
  assign bus.count_o   = count_q;

endmodule
